// File: rtl/vga_timing_gen_if.sv
// VGA raster-timing bundle: run enable in, pixel strobe, coordinates, syncs and frame strobe out.
interface vga_timing_gen_if;
  logic       en;
  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_tick;

  modport master (
    input  en,
    output pix_tick, h_cnt, v_cnt, hsync, vsync, video_on, frame_tick
  );

  modport slave (
    output en,
    input  pix_tick, h_cnt, v_cnt, hsync, vsync, video_on, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing from a fast system clock: internal pixel strobe divider,
// h/v counters and registered syncs, video_on and frame strobe.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_timing_gen_if.master vga
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  if (CLK_DIV < 2 || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_cfg
    $error("vga_timing_gen: illegal CLK_DIV or raster totals");
  end

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt, v_cnt, h_next, v_next;
  logic             pix_tick, frame_tick, hsync, vsync, video_on;
  logic             div_last, h_wrap, v_wrap;
  logic             hsync_next, vsync_next, video_on_next;

  // Syncs and video_on are decoded from the post-advance coordinates so they
  // land on the same edge as h_cnt/v_cnt.
  always_comb begin
    div_last = (div == DIV_LAST);
    h_wrap   = (h_cnt == H_LAST);
    v_wrap   = h_wrap && (v_cnt == V_LAST);
    h_next   = h_wrap ? '0 : h_cnt + 10'd1;
    v_next   = v_cnt;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_cnt + 10'd1;
    end
    hsync_next    = (h_next >= HS_START && h_next <= HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_next    = (v_next >= VS_START && v_next <= VS_END) ? SYNC_POL : ~SYNC_POL;
    video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pix_tick   <= 1'b0;
      frame_tick <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      video_on   <= 1'b1;
    end else if (vga.en) begin
      pix_tick   <= div_last;
      frame_tick <= div_last && v_wrap;
      if (div_last) begin
        div      <= '0;
        h_cnt    <= h_next;
        v_cnt    <= v_next;
        hsync    <= hsync_next;
        vsync    <= vsync_next;
        video_on <= video_on_next;
      end else begin
        div <= div + 1'b1;
      end
    end else begin
      pix_tick   <= 1'b0;
      frame_tick <= 1'b0;
    end
  end

  assign vga.pix_tick   = pix_tick;
  assign vga.h_cnt      = h_cnt;
  assign vga.v_cnt      = v_cnt;
  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.video_on   = video_on;
  assign vga.frame_tick = frame_tick;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a reduced raster on two instances
// (CLK_DIV=4/active-low syncs and CLK_DIV=2/active-high syncs).
module tb_vga_timing_gen;
  localparam int unsigned HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HV + HF + HS + HB;   // 15
  localparam int unsigned VT = VV + VF + VS + VB;   // 8
  localparam int unsigned FRAME = HT * VT;          // 120 pixels

  typedef struct {
    int unsigned h;
    int unsigned v;
    logic        hs;
    logic        vs;
    logic        von;
    logic        ft;
    int unsigned gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic       tick_o[2];
  logic [9:0] h_o[2];
  logic [9:0] v_o[2];
  logic       hs_o[2], vs_o[2], von_o[2], ft_o[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vga_timing_gen_if vif ();
    assign vif.en   = en;
    assign tick_o[g] = vif.pix_tick;
    assign h_o[g]    = vif.h_cnt;
    assign v_o[g]    = vif.v_cnt;
    assign hs_o[g]   = vif.hsync;
    assign vs_o[g]   = vif.vsync;
    assign von_o[g]  = vif.video_on;
    assign ft_o[g]   = vif.frame_tick;

    vga_timing_gen #(
      .CLK_DIV  ((g == 0) ? 4 : 2),
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL ((g == 1) ? 1'b1 : 1'b0)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .vga  (vif)
    );
  end

  exp_t        sbq[2][$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned div_of(input int g);
    return (g == 0) ? 4 : 2;
  endfunction

  function automatic exp_t mk(input int g, input int unsigned p, input int unsigned gap);
    exp_t e;
    logic pol;
    pol   = (g == 1);
    e.h   = p % HT;
    e.v   = p / HT;
    e.hs  = (e.h >= HV + HF && e.h < HV + HF + HS) ? pol : ~pol;
    e.vs  = (e.v >= VV + VF && e.v < VV + VF + VS) ? pol : ~pol;
    e.von = (e.h < HV) && (e.v < VV);
    e.ft  = (p == 0);
    e.gap = gap;
    return e;
  endfunction

  // Stimulus side: clock-level reference of divider and raster position.
  int unsigned mdiv[2], mp[2], mgap[2];
  int unsigned nt0;

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      mdiv[g] = 0;
      mp[g]   = 0;
      mgap[g] = 0;
    end
  endtask

  task automatic step(input logic en_val, input logic release_rst);
    @(negedge clk);
    #2;
    if (release_rst) rst_n = 1'b1;
    en = en_val;
    for (int g = 0; g < 2; g++) begin
      mgap[g]++;
      if (en_val) begin
        if (mdiv[g] == div_of(g) - 1) begin
          mdiv[g] = 0;
          mp[g]   = (mp[g] + 1) % FRAME;
          sbq[g].push_back(mk(g, mp[g], mgap[g]));
          mgap[g] = 0;
          if (g == 0) nt0++;
        end else begin
          mdiv[g]++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    nt0   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (5) @(negedge clk);
    step(1'b1, 1'b1);
    while (mp[0] != 5) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (37) step(1'b0, 1'b0);
    while (nt0 < 2 * FRAME + 40) step(1'b1, 1'b0);
    // Asynchronous reset mid-frame, between clock edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    step(1'b1, 1'b1);
    repeat (200) step(1'b1, 1'b0);
    done = 1'b1;
  end

  // Monitor side: owns every comparison and the counters.
  task automatic chk(input string name, input int g, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, g, act, exp, $time);
    end
  endtask

  function automatic exp_t reset_exp(input int g);
    exp_t e;
    e.h   = 0;
    e.v   = 0;
    e.hs  = (g == 1) ? 1'b0 : 1'b1;
    e.vs  = e.hs;
    e.von = 1'b1;
    e.ft  = 1'b0;
    e.gap = 0;
    return e;
  endfunction

  task automatic check_state(input int g, input exp_t e, input string tag);
    chk({tag, "_h_cnt"},    g, h_o[g],   e.h);
    chk({tag, "_v_cnt"},    g, v_o[g],   e.v);
    chk({tag, "_hsync"},    g, hs_o[g],  e.hs);
    chk({tag, "_vsync"},    g, vs_o[g],  e.vs);
    chk({tag, "_video_on"}, g, von_o[g], e.von);
    chk({tag, "_frame_tick"}, g, ft_o[g], e.ft);
  endtask

  exp_t        cur[2];
  int unsigned last[2];

  initial begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      cur[g]  = reset_exp(g);
      last[g] = 0;
    end
    while (!done) begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        for (int g = 0; g < 2; g++) begin
          check_state(g, reset_exp(g), "rst");
          chk("rst_pix_tick", g, tick_o[g], 0);
          cur[g]  = reset_exp(g);
          last[g] = cyc;
        end
      end else begin
        for (int g = 0; g < 2; g++) begin
          if (tick_o[g]) begin
            if (sbq[g].size() == 0) begin
              chk("unexpected_pix_tick", g, 1, 0);
            end else begin
              e = sbq[g].pop_front();
              chk("tick_gap", g, cyc - last[g], e.gap);
              check_state(g, e, "tick");
              cur[g] = e;
            end
            last[g] = cyc;
          end else begin
            e    = cur[g];
            e.ft = 1'b0;
            check_state(g, e, "hold");
          end
        end
      end
    end
    for (int g = 0; g < 2; g++) chk("missing_pix_ticks", g, sbq[g].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumer end of the pixel-clock path: one fast system clock in, all VGA raster timing out.
- Derives a one-cycle pixel strobe internally by counting CLK_DIV system clocks, so the design needs no derived clock net.
- Runs horizontal/vertical counters and produces registered hsync, vsync, video_on, pixel coordinates and a frame strobe.
- Feeds the game renderer and the VGA pins.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range >= 2.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels; H_TOTAL = 800.
- V_VISIBLE, 480, active lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines; V_TOTAL = 525.
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; low freezes all state.
- pix_tick  output  1  one-clk strobe, once per pixel period.
- h_cnt  output  10  current pixel column, 0..H_TOTAL-1.
- v_cnt  output  10  current line, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- video_on  output  1  high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- frame_tick  output  1  one-clk strobe when the raster wraps to (0,0).

Behaviour:
- Reset (async, rst_n low):
  - div counter = 0, h_cnt = 0, v_cnt = 0, pix_tick = 0, frame_tick = 0.
  - hsync = vsync = ~SYNC_POL.
  - video_on = 1, consistent with (0,0).
  - Release is synchronous to clk; the first pix_tick occurs CLK_DIV clocks after the first enabled edge.
- Divider:
  - div counts 0..CLK_DIV-1 when en = 1 and wraps to 0.
  - pix_tick is registered, high for exactly one clk in the cycle after div = CLK_DIV-1.
- Counter advance, on each edge where div = CLK_DIV-1 and en = 1:
  - h_cnt increments.
  - h_cnt = H_TOTAL-1 -> h_cnt = 0 and v_cnt increments.
  - v_cnt = V_TOTAL-1 at that same wrap -> v_cnt = 0.
- Counters never exceed TOTAL-1; no other wrap conditions exist.
- Output decode:
  - hsync, vsync and video_on are registered and decoded from the next counter values, so they update on the same edge as h_cnt/v_cnt. Zero-cycle skew between coordinates and syncs.
  - hsync = SYNC_POL when H_VISIBLE+H_FP <= h_cnt <= H_VISIBLE+H_FP+H_SYNC-1 (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_VISIBLE+V_FP <= v_cnt <= V_VISIBLE+V_FP+V_SYNC-1 (490..491), else ~SYNC_POL.
- frame_tick:
  - High for one clk on the edge where the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0), coincident with that pix_tick.
  - Not asserted at reset release.
- en = 0:
  - div, h_cnt, v_cnt and the sync/video_on outputs hold their values.
  - pix_tick and frame_tick are forced 0 on the next edge.
  - en returning high resumes counting from the held div value; no pixel is lost or duplicated.
- Reset mid-frame: immediate async return to the reset values above, regardless of en or div phase.
- Widths: 10-bit counters cover a total of up to 1023; totals above that are illegal configurations.

Test Plan:
- Reset check: hold rst_n low 5 clk, then release with en = 1 -> h_cnt = 0, v_cnt = 0, hsync = vsync = 1, video_on = 1 during reset; first pix_tick on the 4th clk after release; pix_tick period exactly 4 clk thereafter.
- Line timing: run 1 line -> h_cnt goes 0..799 then 0; hsync low for exactly 96 pixel periods (384 clk) starting at h_cnt = 656; video_on low from h_cnt = 640 to 799; line period 3200 clk.
- Frame timing: run 2 frames -> vsync low only on v_cnt = 490 and 491 (6400 clk); frame_tick pulses exactly once per 1,680,000 clk, coincident with (h_cnt, v_cnt) becoming (0,0).
- Enable hold: drop en for 37 clk at h_cnt = 300 -> all outputs frozen, no pix_tick; after en returns, h_cnt = 301 appears after the remaining divider count; total line length = 3200 + 37 clk.
- Async reset mid-frame: assert rst_n low at v_cnt = 200, h_cnt = 700, between clock edges -> outputs hit reset values before the next edge; after release, counting restarts from (0,0) with no frame_tick.
- Parameter sweep: CLK_DIV = 2, SYNC_POL = 1 -> pix_tick every 2 clk; hsync/vsync high during the sync windows and low elsewhere; reset value 0.
